// File: rtl/pingpong_dpram_buffer_if.sv
// Bundle of producer/consumer signals for the ping-pong double buffer.
// The master modport is the tile-loader/compute side; the slave modport is the buffer.
interface pingpong_dpram_buffer_if #(
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned DWIDTH = 60
);
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              wr_done;
    logic              wr_ready;
    logic              wr_bank;
    logic              rd_en;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              rd_ready;
    logic              rd_bank;
    logic [1:0]        occupancy;
    logic              err_wr;
    logic              err_rd;

    modport master (
        output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        input  wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, occupancy, err_wr, err_rd
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        output wr_ready, wr_bank, rd_data, rd_valid, rd_ready, rd_bank, occupancy, err_wr, err_rd
    );
endinterface

// File: rtl/pingpong_dpram_buffer.sv
// Two-bank ping-pong buffer acting as a 2-entry FIFO of whole buffers, with
// explicit wr_done/rd_done bank swaps, 1-cycle read latency and sticky error flags.
module pingpong_dpram_buffer #(
    parameter int unsigned AWIDTH    = 11,
    parameter int unsigned NUM_WORDS = 2048,
    parameter int unsigned DWIDTH    = 60
) (
    input logic                   clk,
    input logic                   reset,
    pingpong_dpram_buffer_if.slave bus
);

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0] rd_data_q, rd_data_d;
    logic              err_wr_q, err_wr_d;
    logic              err_rd_q, err_rd_d;

    logic wr_ready, rd_ready;
    logic wr_fire, wr_swap, rd_fire, rd_swap;
    logic [DWIDTH-1:0] bank_rdata [2];

    assign wr_ready = ~full_q[wr_bank_q];
    assign rd_ready = full_q[rd_bank_q];

    assign wr_fire = bus.wr_en & wr_ready;
    assign wr_swap = bus.wr_done & wr_ready;
    assign rd_fire = bus.rd_en & rd_ready;
    assign rd_swap = bus.rd_done & rd_ready;

    // Port 1 writes, port 2 reads; a bank's read port is gated off unless it is rd_bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DWIDTH-1:0] mem [NUM_WORDS];

        always_ff @(posedge clk) begin
            if (wr_fire && (wr_bank_q == 1'(b))) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
        end

        assign bank_rdata[b] = (rd_bank_q == 1'(b)) ? mem[bus.rd_addr] : '0;
    end

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_valid_d = rd_fire;
        rd_data_d  = rd_data_q;
        err_wr_d   = err_wr_q | ((bus.wr_en | bus.wr_done) & ~wr_ready);
        err_rd_d   = err_rd_q | ((bus.rd_en | bus.rd_done) & ~rd_ready);

        if (rd_fire) begin
            rd_data_d = bank_rdata[0] | bank_rdata[1];
        end
        // Legal wr_swap and rd_swap can never target the same bank, so both updates compose.
        if (wr_swap) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_swap) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.rd_ready  = rd_ready;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.occupancy = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign bus.err_wr    = err_wr_q;
    assign bus.err_rd    = err_rd_q;

endmodule

// File: tb/tb_pingpong_dpram_buffer.sv
// Directed bench for pingpong_dpram_buffer: read results are scoreboarded through
// a queue filled when each read is issued and drained on the following cycle.
module tb_pingpong_dpram_buffer;
    localparam int unsigned AWIDTH    = 11;
    localparam int unsigned NUM_WORDS = 2048;
    localparam int unsigned DWIDTH    = 60;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic              exp_valid_q [$];
    logic [DWIDTH-1:0] exp_data_q  [$];

    always #5 clk = ~clk;

    pingpong_dpram_buffer_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus_if ();

    pingpong_dpram_buffer #(
        .AWIDTH   (AWIDTH),
        .NUM_WORDS(NUM_WORDS),
        .DWIDTH   (DWIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit later; drain any pending read expectation.
    task automatic tick();
        logic              v;
        logic [DWIDTH-1:0] d;
        @(posedge clk);
        #1;
        if (exp_valid_q.size() != 0) begin
            v = exp_valid_q.pop_front();
            d = exp_data_q.pop_front();
            chk("rd_valid", 64'(bus_if.rd_valid), 64'(v));
            if (v) chk("rd_data", 64'(bus_if.rd_data), 64'(d));
        end
    endtask

    task automatic write_word(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        tick();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic pulse_done(input logic wd, input logic rdn);
        bus_if.wr_done = wd;
        bus_if.rd_done = rdn;
        tick();
        bus_if.wr_done = 1'b0;
        bus_if.rd_done = 1'b0;
    endtask

    task automatic read_word(input logic [AWIDTH-1:0] a, input logic v, input logic [DWIDTH-1:0] d);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = a;
        exp_valid_q.push_back(v);
        exp_data_q.push_back(d);
        tick();
        bus_if.rd_en   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.wr_done = 1'b0;
        bus_if.rd_en   = 1'b0;
        bus_if.rd_addr = '0;
        bus_if.rd_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_wr_ready", 64'(bus_if.wr_ready), 64'd1);
        chk("rst_rd_ready", 64'(bus_if.rd_ready), 64'd0);
        chk("rst_wr_bank", 64'(bus_if.wr_bank), 64'd0);
        chk("rst_rd_bank", 64'(bus_if.rd_bank), 64'd0);
        chk("rst_occupancy", 64'(bus_if.occupancy), 64'd0);
        chk("rst_rd_valid", 64'(bus_if.rd_valid), 64'd0);
        chk("rst_rd_data", 64'(bus_if.rd_data), 64'd0);
        chk("rst_err_wr", 64'(bus_if.err_wr), 64'd0);
        chk("rst_err_rd", 64'(bus_if.err_rd), 64'd0);
        reset = 1'b0;

        // Fill bank0 and hand it over
        for (int i = 0; i < 4; i++) write_word(AWIDTH'(i), DWIDTH'(32'h100 + i));
        chk("b0_rd_ready_pre", 64'(bus_if.rd_ready), 64'd0);
        pulse_done(1'b1, 1'b0);
        chk("b0_rd_ready", 64'(bus_if.rd_ready), 64'd1);
        chk("b0_wr_bank", 64'(bus_if.wr_bank), 64'd1);
        chk("b0_occupancy", 64'(bus_if.occupancy), 64'd1);
        chk("b0_wr_ready", 64'(bus_if.wr_ready), 64'd1);
        read_word(11'd2, 1'b1, 60'h102);
        tick();
        chk("rd_data_hold", 64'(bus_if.rd_data), 64'h102);
        chk("rd_valid_idle", 64'(bus_if.rd_valid), 64'd0);

        // Fill bank1: both full, then a dropped write
        for (int i = 0; i < 4; i++) write_word(AWIDTH'(i), DWIDTH'(32'h200 + i));
        pulse_done(1'b1, 1'b0);
        chk("full_occupancy", 64'(bus_if.occupancy), 64'd2);
        chk("full_wr_ready", 64'(bus_if.wr_ready), 64'd0);
        chk("full_wr_bank", 64'(bus_if.wr_bank), 64'd0);
        chk("full_err_wr_pre", 64'(bus_if.err_wr), 64'd0);
        write_word(11'd0, 60'hFFF);
        chk("full_err_wr", 64'(bus_if.err_wr), 64'd1);
        read_word(11'd0, 1'b1, 60'h100);

        // Read with rd_done on bank0: data from old bank, then bank0 becomes writable
        bus_if.rd_done = 1'b1;
        read_word(11'd3, 1'b1, 60'h103);
        bus_if.rd_done = 1'b0;
        chk("swap_rd_bank", 64'(bus_if.rd_bank), 64'd1);
        chk("swap_occupancy", 64'(bus_if.occupancy), 64'd1);
        chk("swap_wr_ready", 64'(bus_if.wr_ready), 64'd1);
        chk("swap_rd_ready", 64'(bus_if.rd_ready), 64'd1);
        chk("swap_err_rd", 64'(bus_if.err_rd), 64'd0);
        read_word(11'd0, 1'b1, 60'h200);

        // Simultaneous wr_done and rd_done from a clean state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_err_wr", 64'(bus_if.err_wr), 64'd0);
        for (int i = 0; i < 4; i++) write_word(AWIDTH'(i), DWIDTH'(32'h400 + i));
        pulse_done(1'b1, 1'b0);
        pulse_done(1'b1, 1'b1);
        chk("sim_occupancy", 64'(bus_if.occupancy), 64'd1);
        chk("sim_wr_bank", 64'(bus_if.wr_bank), 64'd0);
        chk("sim_rd_bank", 64'(bus_if.rd_bank), 64'd1);
        chk("sim_err_wr", 64'(bus_if.err_wr), 64'd0);
        chk("sim_err_rd", 64'(bus_if.err_rd), 64'd0);
        // Bank1 was never rewritten after reset: RAM contents survive reset
        read_word(11'd1, 1'b1, 60'h201);

        // Drain bank1 then read from an empty buffer
        pulse_done(1'b0, 1'b1);
        chk("empty_rd_ready", 64'(bus_if.rd_ready), 64'd0);
        chk("empty_occupancy", 64'(bus_if.occupancy), 64'd0);
        read_word(11'd0, 1'b0, 60'h0);
        chk("empty_err_rd", 64'(bus_if.err_rd), 64'd1);
        chk("empty_rd_data_hold", 64'(bus_if.rd_data), 64'h201);

        // Reset with both banks full and a read issued in the same cycle
        write_word(11'd0, 60'h500);
        pulse_done(1'b1, 1'b0);
        write_word(11'd0, 60'h600);
        pulse_done(1'b1, 1'b0);
        chk("pre_rst_occupancy", 64'(bus_if.occupancy), 64'd2);
        reset = 1'b1;
        read_word(11'd0, 1'b0, 60'h0);
        reset = 1'b0;
        chk("mid_rst_rd_data", 64'(bus_if.rd_data), 64'd0);
        chk("mid_rst_occupancy", 64'(bus_if.occupancy), 64'd0);
        chk("mid_rst_wr_ready", 64'(bus_if.wr_ready), 64'd1);
        chk("mid_rst_rd_ready", 64'(bus_if.rd_ready), 64'd0);
        chk("mid_rst_banks", 64'({bus_if.wr_bank, bus_if.rd_bank}), 64'd0);
        chk("mid_rst_errs", 64'({bus_if.err_wr, bus_if.err_rd}), 64'd0);
        write_word(11'd5, 60'hABC);
        pulse_done(1'b1, 1'b0);
        read_word(11'd5, 1'b1, 60'hABC);

        if (exp_valid_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_valid_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pingpong_dpram_buffer.md
Name: pingpong_dpram_buffer

Overview:
- Parametrised double-buffered (ping-pong) memory: two identical dual-port RAM banks with explicit producer/consumer bank-swap handshakes.
- The producer fills one bank while the consumer reads the other. Banks behave as a 2-entry FIFO of whole buffers.
- Sits between a tile loader and a compute array; it replaces the fixed 2048x60 free-running double buffer with flow-controlled swapping and error flags.

Parameters:
- AWIDTH, 11, address width per bank
- NUM_WORDS, 2048, words per bank (must be <= 2**AWIDTH)
- DWIDTH, 60, data width

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write word into current write bank
- wr_addr  input  AWIDTH  write address
- wr_data  input  DWIDTH  write data
- wr_done  input  1  pulse: producer finished current write bank
- wr_ready  output  1  current write bank is free to fill
- wr_bank  output  1  index of current write bank
- rd_en  input  1  read word from current read bank
- rd_addr  input  AWIDTH  read address
- rd_data  output  DWIDTH  read data
- rd_valid  output  1  rd_data valid this cycle
- rd_done  input  1  pulse: consumer finished current read bank
- rd_ready  output  1  current read bank holds a completed buffer
- rd_bank  output  1  index of current read bank
- occupancy  output  2  number of full banks (0..2)
- err_wr  output  1  sticky: wr_en or wr_done while !wr_ready
- err_rd  output  1  sticky: rd_en or rd_done while !rd_ready

Behaviour:
- State: full[1:0], wr_bank, rd_bank, rd_valid pipeline register, err flags.
- Reset values: full=0, wr_bank=0, rd_bank=0, rd_data=0, rd_valid=0, err_wr=0, err_rd=0. Derived outputs therefore reset to wr_ready=1, rd_ready=0, occupancy=0. RAM contents are not cleared.
- Derived outputs, combinational from registers: wr_ready = !full[wr_bank]; rd_ready = full[rd_bank]; occupancy = full[0]+full[1].
- Write path: if wr_en && wr_ready, RAM[wr_bank][wr_addr] <= wr_data. If wr_en && !wr_ready, the write is dropped and err_wr is set.
- wr_done && wr_ready: full[wr_bank] <= 1 and wr_bank toggles next cycle. A wr_en in the same cycle is still written to the old bank.
- wr_done && !wr_ready: ignored; err_wr is set.
- Read path: rd_en && rd_ready starts a read of RAM[rd_bank][rd_addr].
  - Latency is exactly 1 cycle: rd_valid=1 and rd_data=word on the next cycle.
  - The bank is sampled at issue.
- rd_en && !rd_ready: rd_valid=0 next cycle; err_rd is set.
- rd_data holds its last value when rd_valid=0.
- rd_done && rd_ready: full[rd_bank] <= 0 and rd_bank toggles next cycle. A rd_en in the same cycle reads the old bank, and its data returns normally.
- rd_done && !rd_ready: ignored; err_rd is set.
- Simultaneous wr_done and rd_done, both legal: both take effect. Occupancy is unchanged if they target different banks.
  - Same-bank case: wr_done requires !full and rd_done requires full, so both cannot be legal on the same bank.
  - A bank freed by rd_done becomes writable the following cycle, not the same cycle.
- Banks never see a write and a read on the same bank in the same cycle under legal use.
  - RAM ports: port 1 = write, port 2 = read, per bank.
  - A bank's read port is disabled when the bank is not rd_bank.
- Addresses >= NUM_WORDS: behaviour is undefined and not checked.
- Reset mid-operation: all state returns to reset values next cycle. Any in-flight read is dropped (rd_valid=0). Err flags are cleared.

Test Plan:
- Reset -> wr_ready=1, rd_ready=0, wr_bank=0, rd_bank=0, occupancy=0, rd_valid=0, rd_data=0, err_wr=err_rd=0.
- Write addr 0..3 with data 0x100+i, pulse wr_done -> next cycle rd_ready=1, wr_bank=1, occupancy=1. Then rd_en addr 2 -> one cycle later rd_valid=1, rd_data=0x102.
- Fill bank1 with 0x200+i, pulse wr_done -> occupancy=2, wr_ready=0. Then wr_en addr 0 data 0xFFF -> err_wr=1. Reading bank0 addr 0 returns 0x100, and bank1 addr 0 later reads 0x200.
- With occupancy=1, pulse wr_done and rd_done in the same cycle -> occupancy stays 1, both wr_bank and rd_bank toggle, err flags remain 0.
- rd_en addr 3 together with rd_done on bank0 -> next cycle rd_valid=1, rd_data=0x103 (old bank), rd_bank=1. Then rd_en with rd_ready=0 -> rd_valid=0 and err_rd=1.
- Assert reset while occupancy=2 and a read is in flight -> next cycle all outputs at reset values, rd_valid=0. After one write and wr_done, the bank reads back the new data.
